// File: rtl/hilehase_event_capture_pkg.sv
// hilehase_pkg: shared types for the HILEHASE event capture front end.
package hilehase_pkg;
    localparam int EV_TS_W = 32;
    typedef logic [1:0] sig_code_t;
    localparam sig_code_t CODE_0 = 2'd0;
    localparam sig_code_t CODE_1 = 2'd1;
    localparam sig_code_t CODE_X = 2'd2;
    localparam sig_code_t CODE_Z = 2'd3;
    // "time" is reserved in SV, so the timestamp field is named ts
    typedef struct packed {
        logic [7:0]         id;
        sig_code_t          val;
        logic [EV_TS_W-1:0] ts;
    } hilehase_event_t;
    typedef enum logic [1:0] {ARM, INIT, RUN} state_t;
endpackage

// File: rtl/hilehase_event_capture_if.sv
// hilehase_event_capture_if: valid/ready event port towards the DPI bridge stage.
interface hilehase_event_capture_if #(
    parameter int TS_W = 32
);
    logic            ev_valid;
    logic            ev_ready;
    logic [7:0]      ev_id;
    logic [1:0]      ev_val;
    logic [TS_W-1:0] ev_time;
    modport master(output ev_valid, ev_id, ev_val, ev_time, input ev_ready);
    modport slave(input ev_valid, ev_id, ev_val, ev_time, output ev_ready);
endinterface

// File: rtl/hilehase_event_fifo.sv
// hilehase_event_fifo: synchronous show-ahead FIFO of hilehase_event_t.
module hilehase_event_fifo
    import hilehase_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  hilehase_event_t i_wdata,
    output hilehase_event_t o_rdata,
    output logic            o_full,
    output logic            o_empty,
    output logic [AW:0]     o_count
);
    localparam int CW = AW + 1;
    hilehase_event_t r_mem[DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;

    always_ff @(posedge clk) if (i_push) r_mem[r_wp] <= i_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + AW'(1);
            if (i_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_rdata = r_mem[r_rp];
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
endmodule

// File: rtl/hilehase_event_capture.sv
// hilehase_event_capture: timestamps per-signal value changes and queues them as events.
// Optional HILEHASE_INIT_EVENT_EN emits one initial-value event per signal after reset.
module hilehase_event_capture
    import hilehase_pkg::*;
#(
    parameter int NUM_SIG = 6,
    parameter int DEPTH   = 16,
    parameter int TS_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*NUM_SIG-1:0]     sig_code,
    hilehase_event_capture_if.master ev,
    output logic [15:0]              drop_cnt,
    output logic                     fifo_full
);
    localparam int SW = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef HILEHASE_INIT_EVENT_EN
    localparam state_t ARM_NEXT = INIT;
`else
    localparam state_t ARM_NEXT = RUN;
`endif
    state_t r_state, w_state_nxt;
    logic [TS_W-1:0] r_ts;
    sig_code_t r_prev[NUM_SIG];
    sig_code_t r_pend_val[NUM_SIG];
    sig_code_t w_sig[NUM_SIG];
    logic [TS_W-1:0] r_pend_ts[NUM_SIG];
    logic [NUM_SIG-1:0] r_pend, w_chg, w_pushed;
    logic [15:0] r_drop;
    logic [16:0] w_drop_sum;
    logic [7:0] w_ndrop;
    logic [SW-1:0] w_sel;
    logic w_push, w_pop, w_full, w_empty;
    logic [CW-1:0] w_count;
    hilehase_event_t w_wdata, w_head;

    always_comb w_state_nxt = (r_state == ARM) ? ARM_NEXT : RUN;

    always_comb begin
        w_sel = '0;
        for (int i = NUM_SIG - 1; i >= 0; i--) if (r_pend[i]) w_sel = SW'(i);
    end

    // a pop frees a slot on the same edge, so a full FIFO can still accept a push
    assign w_pop   = !w_empty && ev.ev_ready;
    assign w_push  = |r_pend && (w_count != CW'(DEPTH) || w_pop);
    assign w_wdata = '{id: 8'(w_sel) + 8'd1, val: r_pend_val[w_sel], ts: EV_TS_W'(r_pend_ts[w_sel])};

    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            w_sig[i]    = sig_code[2*i +: 2];
            w_chg[i]    = (r_state == RUN) && (w_sig[i] != r_prev[i]);
            w_pushed[i] = w_push && (w_sel == SW'(i));
            w_ndrop     = w_ndrop + 8'(w_chg[i] && r_pend[i] && !w_pushed[i]);
        end
        w_drop_sum = {1'b0, r_drop} + 17'(w_ndrop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARM;
            r_ts    <= '0;
            r_pend  <= '0;
            r_drop  <= '0;
            for (int i = 0; i < NUM_SIG; i++) begin
                r_prev[i]     <= CODE_0;
                r_pend_val[i] <= CODE_0;
                r_pend_ts[i]  <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_ts    <= r_ts + TS_W'(1);
            r_drop  <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            for (int i = 0; i < NUM_SIG; i++) begin
                if (r_state == ARM || w_chg[i]) r_prev[i] <= w_sig[i];
                if (r_state == INIT) begin
                    r_pend[i]     <= 1'b1;
                    r_pend_val[i] <= r_prev[i];
                    r_pend_ts[i]  <= '0;
                end else if (w_chg[i]) begin
                    r_pend[i]     <= 1'b1;
                    r_pend_val[i] <= w_sig[i];
                    r_pend_ts[i]  <= r_ts;
                end else if (w_pushed[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    hilehase_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_wdata(w_wdata),
        .o_rdata(w_head),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_count(w_count)
    );

    assign ev.ev_valid = !w_empty;
    assign ev.ev_id    = w_empty ? '0 : w_head.id;
    assign ev.ev_val   = w_empty ? '0 : w_head.val;
    assign ev.ev_time  = w_empty ? '0 : w_head.ts[TS_W-1:0];
    assign drop_cnt    = r_drop;
    assign fifo_full   = w_full;
endmodule

// File: tb/tb_hilehase_event_capture.sv
// tb_hilehase_event_capture: randomized self-checking bench against an event-queue reference model.
module tb_hilehase_event_capture;
    import hilehase_pkg::*;
    localparam int NS    = 6;
    localparam int DEPTH = 16;
`ifdef HILEHASE_INIT_EVENT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2*NS-1:0] sig = '0;
    logic [15:0] drop_cnt;
    logic fifo_full;
    logic [59:0] obs;
    int n_chk = 0;
    int n_pass = 0;

    hilehase_event_capture_if #(.TS_W(32)) evif();

    hilehase_event_capture #(.NUM_SIG(NS), .DEPTH(DEPTH), .TS_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_code (sig),
        .ev       (evif),
        .drop_cnt (drop_cnt),
        .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    assign obs = {evif.ev_valid, evif.ev_id, evif.ev_val, evif.ev_time, drop_cnt, fifo_full};

    // reference model: per-signal pending slot plus an event queue
    int              m_phase;
    logic [31:0]     m_ts;
    logic [1:0]      m_prev[NS];
    bit              m_pend[NS];
    logic [1:0]      m_pval[NS];
    logic [31:0]     m_pts[NS];
    hilehase_event_t m_q[$];
    int              m_drop;

    function automatic void m_reset();
        m_phase = 0;
        m_ts = '0;
        m_q.delete();
        m_drop = 0;
        for (int i = 0; i < NS; i++) begin
            m_prev[i] = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic void m_step(input logic [2*NS-1:0] s, input bit r);
        int sel = -1;
        bit pop, push;
        for (int i = 0; i < NS; i++) if (m_pend[i] && sel < 0) sel = i;
        pop  = (m_q.size() > 0) && r;
        push = (sel >= 0) && (m_q.size() < DEPTH || pop);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back('{id: 8'(sel + 1), val: m_pval[sel], ts: m_pts[sel]});
            m_pend[sel] = 1'b0;
        end
        if (m_phase == 0) begin
            for (int i = 0; i < NS; i++) m_prev[i] = s[2*i +: 2];
            m_phase = INIT_EN ? 1 : 2;
        end else if (m_phase == 1) begin
            for (int i = 0; i < NS; i++) begin
                m_pend[i] = 1'b1;
                m_pval[i] = m_prev[i];
                m_pts[i]  = '0;
            end
            m_phase = 2;
        end else begin
            for (int i = 0; i < NS; i++) if (s[2*i +: 2] != m_prev[i]) begin
                m_prev[i] = s[2*i +: 2];
                if (m_pend[i] && m_drop < 65535) m_drop++;
                m_pend[i] = 1'b1;
                m_pval[i] = s[2*i +: 2];
                m_pts[i]  = m_ts;
            end
        end
        m_ts = m_ts + 32'd1;
    endfunction

    function automatic logic [59:0] exp_all();
        hilehase_event_t h = '0;
        logic v = m_q.size() > 0;
        if (v) h = m_q[0];
        return {v, h.id, h.val, h.ts, 16'(m_drop), m_q.size() == DEPTH};
    endfunction

    task automatic cycle(input logic [2*NS-1:0] s, input bit r);
        sig = s;
        evif.ev_ready = r;
        @(posedge clk);
        m_step(s, r);
        #1;
    endtask

    task automatic apply_reset(input logic [2*NS-1:0] s);
        sig = s;
        rst = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        evif.ev_ready = 1'b1;
        m_reset();
        #1;
        n_chk++;
        if (obs !== 60'd0) $display("FAIL reset_async got %h exp %h", obs, 60'd0);
        else n_pass++;
        @(posedge clk);
        #1;
        n_chk++;
        if (obs !== 60'd0) $display("FAIL reset_held got %h exp %h", obs, 60'd0);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_idle();
        apply_reset('0);
        for (int c = 0; c < 50; c++) begin
            cycle('0, 1'b1);
            n_chk++;
            if (obs !== exp_all()) $display("FAIL idle c=%0d got %h exp %h", c, obs, exp_all());
            else n_pass++;
        end
        n_chk++;
        if (drop_cnt !== 16'd0) $display("FAIL idle_drop got %0d exp 0", drop_cnt);
        else n_pass++;
    endtask

    task automatic test_init();
        logic [2*NS-1:0] s = 12'b01_00_11_10_00_01;
        int nv = 0;
        apply_reset(s);
        for (int c = 0; c < 12; c++) begin
            cycle(s, 1'b1);
            if (evif.ev_valid === 1'b1) nv++;
            n_chk++;
            if (obs !== exp_all()) $display("FAIL init c=%0d got %h exp %h", c, obs, exp_all());
            else n_pass++;
        end
        n_chk++;
        if (nv != (INIT_EN ? 6 : 0)) $display("FAIL init_count got %0d exp %0d", nv, INIT_EN ? 6 : 0);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [2*NS-1:0] s = 12'b00_01_01_00_01_00;
        int ids[3] = '{2, 4, 5};
        logic [42:0] want;
        apply_reset('0);
        for (int c = 0; c < 20 && m_ts != 32'd10; c++) cycle('0, 1'b1);
        cycle(s, 1'b1);
        n_chk++;
        if (evif.ev_valid !== 1'b0) $display("FAIL simul_pending got %b exp 0", evif.ev_valid);
        else n_pass++;
        for (int j = 0; j < 3; j++) begin
            cycle(s, 1'b1);
            want = {1'b1, 8'(ids[j]), 2'd1, 32'd10};
            n_chk++;
            if (obs[59:17] !== want) $display("FAIL simul_ev%0d got %h exp %h", j, obs[59:17], want);
            else n_pass++;
        end
        cycle(s, 1'b1);
        n_chk++;
        if (obs !== exp_all()) $display("FAIL simul_after got %h exp %h", obs, exp_all());
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [2*NS-1:0] s = '0;
        logic [1:0] last_v = 2'd3;
        apply_reset('0);
        for (int c = 0; c < 15; c++) cycle('0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            s[1:0] = (c % 2 == 0) ? 2'd1 : 2'd0;
            cycle(s, 1'b0);
            n_chk++;
            if (obs !== exp_all()) $display("FAIL ovf_fill c=%0d got %h exp %h", c, obs, exp_all());
            else n_pass++;
        end
        n_chk++;
        if (fifo_full !== 1'b1) $display("FAIL ovf_full got %b exp 1", fifo_full);
        else n_pass++;
        n_chk++;
        if (!(drop_cnt > 16'd0)) $display("FAIL ovf_drop got %0d exp >0", drop_cnt);
        else n_pass++;
        for (int c = 0; c < 40; c++) begin
            if (evif.ev_valid === 1'b1 && evif.ev_id === 8'd1) last_v = evif.ev_val;
            cycle(s, 1'b1);
            n_chk++;
            if (obs !== exp_all()) $display("FAIL ovf_drain c=%0d got %h exp %h", c, obs, exp_all());
            else n_pass++;
        end
        n_chk++;
        if (last_v !== s[1:0]) $display("FAIL ovf_last got %0d exp %0d", last_v, s[1:0]);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [2*NS-1:0] s = '0;
        logic [59:0] pexp;
        bit r, stall;
        int k;
        apply_reset('0);
        pexp = exp_all();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, NS - 1);
                s[2*k +: 2] = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 5) == 0) begin
                k = $urandom_range(0, NS - 1);
                s[2*k +: 2] = 2'($urandom_range(0, 3));
            end
            r = (c < 200) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
            stall = pexp[59] && !r;
            cycle(s, r);
            n_chk++;
            if (obs !== exp_all()) $display("FAIL bp c=%0d got %h exp %h", c, obs, exp_all());
            else n_pass++;
            if (stall) begin
                n_chk++;
                if (obs[59:17] !== pexp[59:17]) $display("FAIL bp_stable c=%0d got %h exp %h", c, obs[59:17], pexp[59:17]);
                else n_pass++;
            end
            pexp = exp_all();
        end
    endtask

    task automatic test_reset_mid();
        logic [2*NS-1:0] s = 12'h155;
        logic [2*NS-1:0] s2 = 12'hD55;
        logic [31:0] t6 = 32'hFFFF_FFFF;
        apply_reset('0);
        for (int c = 0; c < 15; c++) cycle('0, 1'b1);
        for (int c = 0; c < 10 && m_q.size() < 5; c++) begin
            cycle(s, 1'b0);
            n_chk++;
            if (obs !== exp_all()) $display("FAIL rmid_fill c=%0d got %h exp %h", c, obs, exp_all());
            else n_pass++;
        end
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        n_chk++;
        if (obs !== 60'd0) $display("FAIL rmid_async got %h exp %h", obs, 60'd0);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(s, 1'b1);
        cycle(s, 1'b1);
        n_chk++;
        if (obs !== exp_all()) $display("FAIL rmid_release got %h exp %h", obs, exp_all());
        else n_pass++;
        cycle(s2, 1'b1);
        for (int c = 0; c < 20; c++) begin
            if (evif.ev_valid === 1'b1 && evif.ev_id === 8'd6) t6 = evif.ev_time;
            cycle(s2, 1'b1);
            n_chk++;
            if (obs !== exp_all()) $display("FAIL rmid_run c=%0d got %h exp %h", c, obs, exp_all());
            else n_pass++;
        end
        n_chk++;
        if (t6 !== 32'd2) $display("FAIL rmid_ts got %0d exp 2", t6);
        else n_pass++;
    endtask

    initial begin
        evif.ev_ready = 1'b1;
        test_reset();
        test_idle();
        test_init();
        test_simultaneous();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
